sprite_bitmap_ram: RTL and testbench
====================================

Name: sprite_bitmap_ram

Overview:
- Writable, double-buffered 16x8 sprite bitmap store.
- Serves the read side of the sprite renderer's bitmap fetch interface: the renderer drives `rom_addr` and samples `rom_bits` on the following edge.
- A host or CPU uploads a new 16-row sprite into the back bank over a valid/ready byte stream.
- The banks swap only on a vsync rising edge, so the renderer never draws a partially written sprite.

Parameters:
- ROWS, 16, number of sprite rows; address width is 4 bits.
- WIDTH, 8, bits per row; the left half of the sprite, which the renderer mirrors.

Ports:
- clk  input  1  system/pixel clock
- reset  input  1  synchronous, active-high reset
- wr_start  input  1  single-cycle pulse: begin (or restart) an upload into the back bank
- wr_valid  input  1  `wr_data` is valid this cycle
- wr_data  input  8  row bitmap byte, row 0 first
- wr_ready  output  1  block accepts a byte this cycle
- vsync  input  1  vertical sync from hvsync_generator; the swap point
- rom_addr  input  4  row select from the renderer
- rom_bits  output  8  bitmap of the selected row, from the front bank
- busy  output  1  an upload is in progress or waiting to swap
- load_done  output  1  one-cycle pulse on the cycle the swap takes effect

Behaviour:
- Storage:
  - Two banks of 16x8 registers.
  - `front` is a 1-bit register selecting the bank that is read; the back bank is `~front`.
- Read path:
  - `rom_bits = bank[front][rom_addr]`, purely combinational, zero latency.
  - The renderer registers `rom_addr` one cycle and latches `rom_bits` the next.
  - Writes never touch the front bank, so `rom_bits` is stable except at a swap edge.
- Reset, on the synchronous `reset` edge:
  - `front`=0; all 32 bytes of both banks cleared to 0, so `rom_bits`=0x00 for every address.
  - State=IDLE, `row`=0, `vsync_d`=0.
  - `wr_ready`=0, `busy`=0, `load_done`=0.
  - Reset mid-upload or mid-pending discards everything; no swap occurs.
- Edge detect: `vsync_d` registers `vsync`; `vs_rise = vsync & ~vsync_d`.
- FSM states: IDLE, RECV, PENDING.
  - IDLE:
    - `wr_ready`=0, `busy`=0.
    - `wr_start` -> RECV with `row`=0.
    - `wr_valid` without `wr_start` is ignored.
  - RECV:
    - `wr_ready`=1, `busy`=1.
    - A beat is accepted when `wr_valid && wr_ready`: `bank[~front][row] <= wr_data`, `row <= row+1`.
    - An accepted beat with `row`==15 -> PENDING (`row` wraps to 0).
    - `wr_start` in RECV restarts at `row`=0. Bytes already written stay in the back bank but will be overwritten.
    - If `wr_start` and `wr_valid` occur in the same RECV cycle, `wr_start` wins: the byte is NOT written and `row`=0.
  - PENDING:
    - `wr_ready`=0, `busy`=1.
    - On `vs_rise`: `front <= ~front`, `load_done` pulses high next cycle for exactly 1 cycle, -> IDLE.
    - `wr_start` in PENDING is ignored; the completed sprite is never lost.
- Swap timing:
  - `vs_rise` is only acted on in PENDING.
  - An edge in the same cycle as the final RECV beat is missed; the swap waits for the next frame.
  - If `vsync` is already high on entry to PENDING, the swap waits for the next rising edge.
- Back-to-back uploads: `wr_start` in the same cycle as `load_done` is accepted (state is IDLE), and the new upload targets the new back bank, i.e. the previous front.
- Arithmetic: `row` is 4 bits and wraps naturally. `wr_data` is stored unmodified; no mirroring is done here.

Test Plan:
- Reset, then sweep `rom_addr` 0..15 -> `rom_bits`=0x00 for all; `wr_ready`=0, `busy`=0, `load_done`=0.
- Reset, `wr_start`, 16 beats of data 0x10+row, then one vsync pulse:
  - Before the vsync edge: `rom_bits`=0x00 everywhere and `busy`=1.
  - One cycle after the edge: `load_done`=1 for 1 cycle and `front`=1.
  - `rom_addr`=5 -> 0x15; `rom_addr`=15 -> 0x1F.
- Upload sprite A (0xA0+row) and swap, then upload sprite B (0xB0+row) with `wr_valid` toggling every other cycle:
  - Before the next vsync edge, `rom_addr`=3 still reads 0xA3.
  - After the edge it reads 0xB3.
- Abort: `wr_start`, 7 beats of 0xEE, `wr_start` again, then 16 beats of 0x40+row, then swap -> `rom_addr`=2 reads 0x42 and 0xEE appears at no address.
- Final beat coincident with a vsync rising edge -> no swap and no `load_done`; the swap happens at the following rising edge.
- Assert `reset` while in PENDING, then pulse `vsync` -> no `load_done`, `rom_bits`=0x00 for all addresses, state IDLE.

Source files
------------

// File: rtl/sprite_bitmap_ram_if.sv
// rtl/sprite_bitmap_ram_if.sv - bundle of upload stream, bitmap fetch and status signals for sprite_bitmap_ram
// Signals:
//   wr_start, wr_valid, wr_data  host -> store : upload control and row bytes (row 0 first)
//   wr_ready                     store -> host : a byte is accepted this cycle
//   vsync                        sync -> store : bank swap point (rising edge)
//   rom_addr                     renderer -> store : row select
//   rom_bits                     store -> renderer : selected row of the front bank
//   busy, load_done              store -> host : upload/swap status
// Modports: master = host/renderer side, slave = sprite_bitmap_ram.
interface sprite_bitmap_ram_if #(
    parameter int ROWS  = 16,
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(ROWS);

    logic             wr_start;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             vsync;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_bits;
    logic             busy;
    logic             load_done;

    modport master (
        output wr_start, wr_valid, wr_data, vsync, rom_addr,
        input  wr_ready, rom_bits, busy, load_done
    );

    modport slave (
        input  wr_start, wr_valid, wr_data, vsync, rom_addr,
        output wr_ready, rom_bits, busy, load_done
    );
endinterface

// File: rtl/sprite_bitmap_ram.sv
// rtl/sprite_bitmap_ram.sv - double-buffered writable sprite bitmap store, swapped on vsync rising edge
// Ports:
//   clk    system/pixel clock
//   reset  synchronous active-high reset; clears both banks and abandons any upload
//   bus    sprite_bitmap_ram_if.slave: upload stream, bitmap fetch, vsync and status
// The front bank feeds rom_bits combinationally; uploads only ever write the back
// bank, and the banks exchange roles on the first vsync rising edge seen after a
// complete 16-row upload.
module sprite_bitmap_ram #(
    parameter int ROWS  = 16,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_bitmap_ram_if.slave   bus
);
    localparam int AW = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    row_q, row_d;
    logic             front_q, front_d;
    logic             vsync_q;
    logic             load_done_q, load_done_d;
    logic [WIDTH-1:0] bank_q [2][ROWS];

    logic             wr_en;
    logic             wr_ready;
    logic             busy;
    logic             vs_rise;

    assign vs_rise = bus.vsync & ~vsync_q;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        front_d     = front_q;
        load_done_d = 1'b0;
        wr_en       = 1'b0;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wr_start) begin
                    state_d = RECV;
                    row_d   = '0;
                end
            end
            RECV: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                // A restart takes priority over a coincident beat, which is dropped.
                if (bus.wr_start) begin
                    row_d = '0;
                end else if (bus.wr_valid) begin
                    wr_en = 1'b1;
                    if (row_q == AW'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = PENDING;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            PENDING: begin
                busy = 1'b1;
                // A new wr_start here is ignored so the finished sprite is kept.
                if (vs_rise) begin
                    front_d     = ~front_q;
                    load_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            front_q     <= 1'b0;
            vsync_q     <= 1'b0;
            load_done_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank_q[b][r] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            front_q     <= front_d;
            vsync_q     <= bus.vsync;
            load_done_q <= load_done_d;
            if (wr_en) begin
                bank_q[~front_q][row_q] <= bus.wr_data;
            end
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.busy      = busy;
    assign bus.load_done = load_done_q;
    assign bus.rom_bits  = bank_q[front_q][bus.rom_addr];

endmodule

// File: tb/tb_sprite_bitmap_ram.sv
// tb/tb_sprite_bitmap_ram.sv - self-checking bench for sprite_bitmap_ram against a sprite-level reference model
module tb_sprite_bitmap_ram;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_bitmap_ram_if #(.ROWS(16), .WIDTH(8)) bus ();

    sprite_bitmap_ram #(.ROWS(16), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which sprite is shown, which bytes have arrived, whether a
    // finished sprite is waiting for the next frame.
    bit         m_uploading;
    bit         m_waiting;
    int         m_filled;
    int         m_front;
    logic [7:0] m_bank [2][16];
    bit         m_vs_prev;
    bit         m_ld;

    task automatic model_clear();
        m_uploading = 0; m_waiting = 0; m_filled = 0; m_front = 0;
        m_vs_prev = 0; m_ld = 0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++) m_bank[b][r] = 8'h00;
    endtask

    task automatic model_update();
        bit edge_seen;
        bit ld_next;
        edge_seen = bus.vsync && !m_vs_prev;
        ld_next = 0;
        if (reset) begin
            model_clear();
            return;
        end
        if (m_uploading) begin
            if (bus.wr_start) m_filled = 0;
            else if (bus.wr_valid) begin
                m_bank[1 - m_front][m_filled] = bus.wr_data;
                m_filled++;
                if (m_filled == 16) begin
                    m_uploading = 0;
                    m_waiting = 1;
                end
            end
        end else if (m_waiting) begin
            if (edge_seen) begin
                m_front = 1 - m_front;
                m_waiting = 0;
                ld_next = 1;
            end
        end else if (bus.wr_start) begin
            m_uploading = 1;
            m_filled = 0;
        end
        m_vs_prev = bus.vsync;
        m_ld = ld_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_start = 0; bus.wr_valid = 0; bus.wr_data = 8'h00;
        bus.vsync = 0; bus.rom_addr = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic upload(input logic [7:0] base, input bit gaps);
        bus.wr_start = 1; tick(); bus.wr_start = 0;
        for (int r = 0; r < 16; r++) begin
            if (gaps) begin bus.wr_valid = 0; tick(); end
            bus.wr_valid = 1; bus.wr_data = base + 8'(r); tick();
        end
        bus.wr_valid = 0;
    endtask

    task automatic swap();
        bus.vsync = 1; tick(); bus.vsync = 0; tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < 16; a++) begin
            bus.rom_addr = 4'(a); tick();
            n_cmp++;
            if (bus.rom_bits !== 8'h00) begin
                n_err++; $display("FAIL reset_rom[%0d]: got %h want 00", a, bus.rom_bits);
            end
        end
        n_cmp++;
        if ({bus.wr_ready, bus.busy, bus.load_done} !== 3'b000) begin
            n_err++; $display("FAIL reset_status: got rdy/busy/ld %b want 000", {bus.wr_ready, bus.busy, bus.load_done});
        end
    endtask

    task automatic test_basic_upload();
        do_reset();
        upload(8'h10, 0);
        for (int a = 0; a < 16; a++) begin
            bus.rom_addr = 4'(a); tick();
            n_cmp++;
            if (bus.rom_bits !== 8'h00 || bus.busy !== 1'b1) begin
                n_err++; $display("FAIL basic_pre_swap[%0d]: got bits %h busy %b want 00 1", a, bus.rom_bits, bus.busy);
            end
        end
        bus.vsync = 1; tick();
        n_cmp++;
        if (bus.load_done !== 1'b1) begin
            n_err++; $display("FAIL basic_load_done: got %b want 1", bus.load_done);
        end
        bus.vsync = 0; bus.rom_addr = 4'd5; tick();
        n_cmp++;
        if (bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL basic_ld_width: got ld %b busy %b want 0 0", bus.load_done, bus.busy);
        end
        n_cmp++;
        if (bus.rom_bits !== 8'h15) begin
            n_err++; $display("FAIL basic_row5: got %h want 15", bus.rom_bits);
        end
        bus.rom_addr = 4'd15; tick();
        n_cmp++;
        if (bus.rom_bits !== 8'h1F) begin
            n_err++; $display("FAIL basic_row15: got %h want 1f", bus.rom_bits);
        end
    endtask

    task automatic test_double_buffer();
        do_reset();
        upload(8'hA0, 0); swap();
        upload(8'hB0, 1);
        bus.rom_addr = 4'd3; tick(); tick();
        n_cmp++;
        if (bus.rom_bits !== 8'hA3) begin
            n_err++; $display("FAIL dbuf_before: got %h want a3", bus.rom_bits);
        end
        swap();
        n_cmp++;
        if (bus.rom_bits !== 8'hB3) begin
            n_err++; $display("FAIL dbuf_after: got %h want b3", bus.rom_bits);
        end
    endtask

    task automatic test_abort();
        do_reset();
        bus.wr_start = 1; tick(); bus.wr_start = 0;
        for (int r = 0; r < 7; r++) begin bus.wr_valid = 1; bus.wr_data = 8'hEE; tick(); end
        // Restart coincides with a valid 0xEE byte; that byte must be dropped.
        bus.wr_start = 1; tick(); bus.wr_start = 0;
        for (int r = 0; r < 16; r++) begin bus.wr_valid = 1; bus.wr_data = 8'h40 + 8'(r); tick(); end
        bus.wr_valid = 0;
        swap();
        for (int a = 0; a < 16; a++) begin
            bus.rom_addr = 4'(a); tick();
            n_cmp++;
            if (bus.rom_bits !== 8'h40 + 8'(a) || bus.rom_bits === 8'hEE) begin
                n_err++; $display("FAIL abort_rom[%0d]: got %h want %h", a, bus.rom_bits, 8'h40 + 8'(a));
            end
        end
    endtask

    task automatic test_coincident_edge();
        do_reset();
        upload(8'h20, 0); swap();
        bus.wr_start = 1; tick(); bus.wr_start = 0;
        for (int r = 0; r < 16; r++) begin
            bus.wr_valid = 1; bus.wr_data = 8'h60 + 8'(r);
            if (r == 15) bus.vsync = 1;
            tick();
        end
        bus.wr_valid = 0; bus.rom_addr = 4'd7;
        n_cmp++;
        if (bus.load_done !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL coinc_edge: got ld %b busy %b want 0 1", bus.load_done, bus.busy);
        end
        tick(); tick();
        n_cmp++;
        if (bus.load_done !== 1'b0 || bus.rom_bits !== 8'h27) begin
            n_err++; $display("FAIL coinc_held_high: got ld %b bits %h want 0 27", bus.load_done, bus.rom_bits);
        end
        bus.vsync = 0; tick();
        bus.vsync = 1; tick();
        n_cmp++;
        if (bus.load_done !== 1'b1 || bus.rom_bits !== 8'h67) begin
            n_err++; $display("FAIL coinc_next_edge: got ld %b bits %h want 1 67", bus.load_done, bus.rom_bits);
        end
        bus.vsync = 0; tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        upload(8'h30, 0);
        bus.wr_start = 1; tick(); bus.wr_start = 0;   // ignored while waiting
        bus.vsync = 1; tick(); bus.vsync = 0;
        n_cmp++;
        if (bus.load_done !== 1'b1) begin
            n_err++; $display("FAIL b2b_first_ld: got %b want 1", bus.load_done);
        end
        bus.wr_start = 1; tick(); bus.wr_start = 0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_restart: got busy %b rdy %b want 1 1", bus.busy, bus.wr_ready);
        end
        for (int r = 0; r < 16; r++) begin bus.wr_valid = 1; bus.wr_data = 8'hC0 + 8'(r); tick(); end
        bus.wr_valid = 0; bus.rom_addr = 4'd9; tick();
        n_cmp++;
        if (bus.rom_bits !== 8'h39) begin
            n_err++; $display("FAIL b2b_old_front: got %h want 39", bus.rom_bits);
        end
        swap();
        n_cmp++;
        if (bus.rom_bits !== 8'hC9) begin
            n_err++; $display("FAIL b2b_new_front: got %h want c9", bus.rom_bits);
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        upload(8'h50, 0);
        reset = 1; tick(); reset = 0;
        bus.vsync = 1; tick();
        n_cmp++;
        if (bus.load_done !== 1'b0 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0) begin
            n_err++; $display("FAIL rstpend_status: got ld %b busy %b rdy %b want 0 0 0", bus.load_done, bus.busy, bus.wr_ready);
        end
        bus.vsync = 0;
        for (int a = 0; a < 16; a++) begin
            bus.rom_addr = 4'(a); tick();
            n_cmp++;
            if (bus.rom_bits !== 8'h00 || bus.load_done !== 1'b0) begin
                n_err++; $display("FAIL rstpend_rom[%0d]: got %h ld %b want 00 0", a, bus.rom_bits, bus.load_done);
            end
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 699) == 0);
            bus.wr_start  = ($urandom_range(0, 79) == 0);
            bus.wr_valid  = $urandom_range(0, 1);
            bus.wr_data   = 8'($urandom);
            bus.rom_addr  = 4'($urandom);
            if ($urandom_range(0, 11) == 0) bus.vsync = ~bus.vsync;
            tick();
            n_cmp++;
            if (bus.rom_bits !== m_bank[m_front][bus.rom_addr] || bus.busy !== (m_uploading || m_waiting) ||
                bus.wr_ready !== m_uploading || bus.load_done !== m_ld) begin
                n_err++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got bits %h busy %b rdy %b ld %b want %h %b %b %b", c,
                             bus.rom_bits, bus.busy, bus.wr_ready, bus.load_done,
                             m_bank[m_front][bus.rom_addr], m_uploading || m_waiting, m_uploading, m_ld);
                bad++;
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        model_clear();
        reset = 1;
        idle_inputs();
        test_reset();
        test_basic_upload();
        test_double_buffer();
        test_abort();
        test_coincident_edge();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
